// File: rtl/lc3_regfile.sv
// LC-3 general-purpose register file: eight WIDTH-bit registers with one write port,
// two combinational read ports (optional write-through bypass) and the N/Z/P flags.
module lc3_regfile #(
    parameter int          WIDTH    = 16,
    parameter bit          BYPASS   = 1'b0,
    parameter logic [2:0]  CC_RESET = 3'b010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_reg,
    input  logic [2:0]       dr,
    input  logic [WIDTH-1:0] bus,
    input  logic             ld_cc,
    input  logic [2:0]       sr1,
    input  logic [2:0]       sr2,
    output logic [WIDTH-1:0] sr1_out,
    output logic [WIDTH-1:0] sr2_out,
    output logic             n,
    output logic             z,
    output logic             p
);

    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] regs_d [8];
    logic [7:0]       wr_en;
    logic [2:0]       cc_q;   // {n, z, p}
    logic [2:0]       cc_d;

    // One-hot write enable: at most one register can capture the bus.
    assign wr_en = ld_reg ? (8'b0000_0001 << dr) : 8'b0000_0000;

    // NOTE: every signal gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = wr_en[i] ? bus : regs_q[i];
        end
        cc_d = cc_q;
        if (ld_cc) begin
            if (bus[WIDTH-1])
                cc_d = 3'b100;
            else if (bus == '0)
                cc_d = 3'b010;
            else
                cc_d = 3'b001;
        end
    end

    // NOTE: the register array is reset explicitly because architectural state must read 0 after reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            cc_q <= CC_RESET;
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
            cc_q <= cc_d;
        end
    end

    // Bypass is suppressed during reset so the ports read the cleared array.
    always_comb begin
        sr1_out = regs_q[sr1];
        sr2_out = regs_q[sr2];
        if (BYPASS && ld_reg && !rst && (sr1 == dr))
            sr1_out = bus;
        if (BYPASS && ld_reg && !rst && (sr2 == dr))
            sr2_out = bus;
    end

    assign n = cc_q[2];
    assign z = cc_q[1];
    assign p = cc_q[0];

endmodule

// File: tb/tb_lc3_regfile.sv
// Randomized and directed checks of lc3_regfile (BYPASS=0 and BYPASS=1 instances side by side)
// against an array-based reference model of the register file and condition codes.
module tb_lc3_regfile;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         ld_reg;
    logic [2:0]   dr;
    logic [W-1:0] bus;
    logic         ld_cc;
    logic [2:0]   sr1;
    logic [2:0]   sr2;

    logic [W-1:0] sr1_a, sr2_a, sr1_b, sr2_b;
    logic         n_a, z_a, p_a, n_b, z_b, p_b;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [W-1:0] ref_r [8];
    logic [2:0]   ref_cc;

    always #5 clk = ~clk;

    lc3_regfile #(.WIDTH(W), .BYPASS(1'b0), .CC_RESET(3'b010)) dut_a (
        .clk(clk), .rst(rst), .ld_reg(ld_reg), .dr(dr), .bus(bus), .ld_cc(ld_cc),
        .sr1(sr1), .sr2(sr2), .sr1_out(sr1_a), .sr2_out(sr2_a), .n(n_a), .z(z_a), .p(p_a)
    );

    lc3_regfile #(.WIDTH(W), .BYPASS(1'b1), .CC_RESET(3'b010)) dut_b (
        .clk(clk), .rst(rst), .ld_reg(ld_reg), .dr(dr), .bus(bus), .ld_cc(ld_cc),
        .sr1(sr1), .sr2(sr2), .sr1_out(sr1_b), .sr2_out(sr2_b), .n(n_b), .z(z_b), .p(p_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [2:0] flags_of(input logic [W-1:0] v);
        if ($signed(v) < 0)
            return 3'b100;
        else if (v == 0)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ref_r[i] = '0;
        ref_cc = 3'b010;
    endtask

    // Expected read value: bypass instance sees the bus when writing the addressed register.
    function automatic logic [W-1:0] exp_read(input bit byp, input logic [2:0] sr);
        if (byp && ld_reg && !rst && (sr == dr))
            return bus;
        return ref_r[sr];
    endfunction

    task automatic check_reads(input string tag);
        check({tag, ".a.sr1"}, 32'(sr1_a), 32'(exp_read(1'b0, sr1)));
        check({tag, ".a.sr2"}, 32'(sr2_a), 32'(exp_read(1'b0, sr2)));
        check({tag, ".b.sr1"}, 32'(sr1_b), 32'(exp_read(1'b1, sr1)));
        check({tag, ".b.sr2"}, 32'(sr2_b), 32'(exp_read(1'b1, sr2)));
    endtask

    task automatic check_flags(input string tag);
        check({tag, ".a.cc"}, 32'({n_a, z_a, p_a}), 32'(ref_cc));
        check({tag, ".b.cc"}, 32'({n_b, z_b, p_b}), 32'(ref_cc));
        check({tag, ".onehot"}, 32'($countones({n_a, z_a, p_a})), 32'd1);
    endtask

    // One full clock cycle: drive on the falling edge, check reads before the
    // rising edge, update the model on the edge, check state just after it.
    task automatic cycle(input string tag, input logic l_reg, input logic [2:0] d,
                         input logic [W-1:0] b, input logic l_cc,
                         input logic [2:0] s1, input logic [2:0] s2);
        @(negedge clk);
        ld_reg = l_reg; dr = d; bus = b; ld_cc = l_cc; sr1 = s1; sr2 = s2;
        #1;
        check_reads({tag, ".pre"});
        @(posedge clk);
        if (l_reg) ref_r[d] = b;
        if (l_cc)  ref_cc = flags_of(b);
        #1;
        ld_reg = 1'b0; ld_cc = 1'b0;
        check_reads({tag, ".post"});
        check_flags(tag);
    endtask

    function automatic logic [W-1:0] rand_bus();
        logic [W-1:0] corners [5];
        corners[0] = 16'h0000; corners[1] = 16'h8000; corners[2] = 16'h7FFF;
        corners[3] = 16'hFFFF; corners[4] = 16'h0001;
        if ($urandom_range(0, 3) == 0)
            return corners[$urandom_range(0, 4)];
        return W'($urandom);
    endfunction

    task automatic random_phase(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            cycle("rand", 1'($urandom), 3'($urandom), rand_bus(), 1'($urandom),
                  3'($urandom), 3'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1; ld_reg = 1'b0; dr = '0; bus = '0; ld_cc = 1'b0; sr1 = '0; sr2 = '0;
        model_reset();

        // Reset held with writes requested: nothing lands, every port reads 0.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ld_reg = 1'b1; ld_cc = 1'b1; dr = 3'(i); bus = 16'hFFFF;
            sr1 = 3'(i); sr2 = 3'(i);
            #1;
            check("rst.a.sr1", 32'(sr1_a), 32'h0);
            check("rst.b.sr2", 32'(sr2_b), 32'h0);
            @(posedge clk);
            #1;
            check_flags("rst");
        end
        @(negedge clk);
        rst = 1'b0; ld_reg = 1'b0; ld_cc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle("rstread", 1'b0, 3'd0, 16'h0, 1'b0, 3'(i), 3'(7 - i));
        end

        // Single write to R3, then read R3/R4 and sweep all.
        cycle("wr3", 1'b1, 3'd3, 16'h1234, 1'b0, 3'd3, 3'd4);
        cycle("rd3", 1'b0, 3'd0, 16'h0, 1'b0, 3'd3, 3'd4);
        check("rd3.value", 32'(sr1_a), 32'h1234);
        for (int i = 0; i < 8; i++) cycle("sweep3", 1'b0, 3'd0, 16'h0, 1'b0, 3'(i), 3'(i));

        // One-hot decode: each register gets a distinct value.
        for (int i = 0; i < 8; i++) cycle("wrall", 1'b1, 3'(i), 16'hA000 + 16'(i), 1'b0, 3'(i), 3'(i));
        for (int i = 0; i < 8; i++) begin
            cycle("rdall", 1'b0, 3'd0, 16'h0, 1'b0, 3'(i), 3'(7 - i));
            check("rdall.value", 32'(sr1_a), 32'hA000 + i);
        end

        // Condition codes, including the two's complement edges.
        cycle("cc8000", 1'b0, 3'd0, 16'h8000, 1'b1, 3'd0, 3'd1);
        check("cc8000.nzp", 32'({n_a, z_a, p_a}), 32'b100);
        cycle("cc0000", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd1);
        check("cc0000.nzp", 32'({n_a, z_a, p_a}), 32'b010);
        cycle("cc0001", 1'b0, 3'd0, 16'h0001, 1'b1, 3'd0, 3'd1);
        check("cc0001.nzp", 32'({n_a, z_a, p_a}), 32'b001);
        cycle("cc7fff", 1'b1, 3'd6, 16'h7FFF, 1'b1, 3'd6, 3'd6);
        check("cc7fff.nzp", 32'({n_a, z_a, p_a}), 32'b001);

        // Same-cycle write/read of R5.
        cycle("byp.old", 1'b1, 3'd5, 16'h1111, 1'b0, 3'd0, 3'd1);
        @(negedge clk);
        ld_reg = 1'b1; dr = 3'd5; bus = 16'hBEEF; sr1 = 3'd5; sr2 = 3'd5;
        #1;
        check("byp.a.same", 32'(sr1_a), 32'h1111);
        check("byp.b.same", 32'(sr1_b), 32'hBEEF);
        @(posedge clk);
        ref_r[5] = 16'hBEEF;
        #1;
        ld_reg = 1'b0;
        check("byp.a.after", 32'(sr1_a), 32'hBEEF);

        random_phase(300);

        // Reset asserted mid-cycle during a write to R2.
        cycle("r2set", 1'b1, 3'd2, 16'h5A5A, 1'b0, 3'd2, 3'd2);
        @(negedge clk);
        ld_reg = 1'b1; dr = 3'd2; bus = 16'hFFFF; ld_cc = 1'b1; sr1 = 3'd2; sr2 = 3'd2;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("midrst.a.sr1", 32'(sr1_a), 32'h0);
        check("midrst.b.sr1", 32'(sr1_b), 32'h0);
        check_flags("midrst");
        @(posedge clk);
        #1;
        check("midrst.edge.a", 32'(sr1_a), 32'h0);
        check("midrst.edge.b", 32'(sr2_b), 32'h0);
        check_flags("midrst.edge");
        @(negedge clk);
        rst = 1'b0; ld_reg = 1'b0; ld_cc = 1'b0;
        #1;
        check("midrst.rel", 32'(sr1_a), 32'h0);

        random_phase(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
